addn_seq: RTL and testbench
===========================

# addn_seq

Multi-limb sequencer for the 16-bit ripple adder `add16`. It accepts a pair of wide operands plus carry-in over a valid/ready handshake. It feeds them to an external `add16` one 16-bit limb per cycle, least significant limb first, chaining `cout` back into `cin`. It assembles the wide sum and carry-out and presents them on a valid/ready output port.

## Interface
- `LIMBS`, default 4: number of 16-bit limbs. Operand width W = 16*LIMBS; legal range 1..16.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept; equals (state==IDLE).
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `in_cin`  in  1  carry-in.
- `add_a`  out  16  limb of A to `add16`.
- `add_b`  out  16  limb of B to `add16`.
- `add_cin`  out  1  chained carry to `add16`.
- `add_sum`  in  16  sum from `add16`; combinational in the same cycle.
- `add_cout`  in  1  carry from `add16`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  W  wide sum.
- `out_cout`  out  1  final carry-out.

## Operation
- States: IDLE, RUN, DONE. A limb index register counts 0..LIMBS-1.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `in_a`/`in_b` into shift registers, load carry register with `in_cin`, clear index, go to RUN.
  - `in_valid` with no accept is ignored; no state changes.
- RUN:
  - `add_a`/`add_b` = low 16 bits of the operand shift registers; `add_cin` = carry register. All three are registered-only.
  - Each edge:
    - capture `add_sum` into limb [index] of the result register;
    - carry register <= `add_cout`;
    - shift operands right 16;
    - index++.
  - On the edge where index==LIMBS-1: go to DONE.
- DONE:
  - `out_valid`=1; `out_sum` = result register; `out_cout` = carry register.
  - All outputs are held stable until `out_ready`=1, then the block goes to IDLE.
  - `in_ready`=0, so new operands are back-pressured.
- IDLE and DONE: `add_a`/`add_b`/`add_cin` driven 0.
- Arithmetic is unsigned mod 2^W; {`out_cout`,`out_sum`} = in_a+in_b+in_cin exactly.

## Timing
- Reset values:
  - state=IDLE, so `in_ready`=1 while `rst_n` is low;
  - `out_valid`=0, `out_sum`=0, `out_cout`=0;
  - `add_a`/`add_b`/`add_cin`=0;
  - index=0.
- Latency: `out_valid` rises LIMBS cycles after the accept edge.
- Throughput: one operation per LIMBS+2 cycles when `out_ready` is tied high.
  - The DONE→IDLE edge does not also accept a new operation.
- LIMBS=1: one RUN cycle, then DONE.
- Reset asserted mid-RUN or in DONE: the operation is discarded and all registers return to reset values immediately. No partial result is ever signalled.
- `out_ready` high while not in DONE has no effect.
- The `add16` combinational path (`add_a` → `add_sum`) must fit in one clock period.

## Configuration
- `ADDN_SEQ_OVF_EN` defined:
  - adds output `out_ovf` (1 bit), meaning two's-complement signed overflow of the W-bit add:
    - `out_ovf` = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]).
  - Registered in DONE alongside `out_sum`, with the same valid/hold rules; reset value 0.
- Not defined: no `out_ovf` port and no extra logic; behaviour is otherwise identical.

## Test plan
All scenarios use LIMBS=4.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → `out_sum`=0, `out_cout`=1, `out_valid` exactly 4 cycles after accept.
- Carry-in only: a=0, b=0, cin=1 → `out_sum`=1, `out_cout`=0, and `add_cin`=1 only in the first RUN cycle.
- Backpressure: complete a=0x0001_0000_0000_FFFF, b=1, hold `out_ready`=0 for 10 cycles with `in_valid`=1 → `out_sum`=0x0001_0000_0001_0000 stable, `in_ready`=0, second request accepted only after the DONE→IDLE edge.
- Reset mid-RUN: assert `rst_n`=0 after 2 limbs captured → `out_valid`=0, `out_sum`=0, `in_ready`=1 at once. The next operation a=5, b=7 returns 12.
- Random: 200 operations, random a/b/cin and random `out_ready` stalls → {`out_cout`,`out_sum`} == a+b+cin for every op.
- Overflow (macro defined): a=0x7FFF_FFFF_FFFF_FFFF, b=1 → `out_ovf`=1; a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF → `out_ovf`=1, `out_cout`=1; a=1, b=1 → `out_ovf`=0.

Source files
------------

// File: rtl/addn_seq_if.sv
// Handshake and add16 limb bus for addn_seq; LIMBS sets the wide operand width.
// Optional out_ovf member exists only when ADDN_SEQ_OVF_EN is defined.
interface addn_seq_if #(
    parameter int LIMBS = 4
);
    localparam int W = 16 * LIMBS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;

    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_sum;
    logic         add_cout;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef ADDN_SEQ_OVF_EN
    logic         out_ovf;
`endif

    // The sequencer itself: consumes operands and add16 results.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
`ifdef ADDN_SEQ_OVF_EN
        , output out_ovf
`endif
    );

    // Operand producer, result consumer and external add16 together.
    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
`ifdef ADDN_SEQ_OVF_EN
        , input out_ovf
`endif
    );
endinterface

// File: rtl/addn_seq.sv
// Multi-limb sequencer driving an external 16-bit add16, LSB limb first, carry chained.
// Define ADDN_SEQ_OVF_EN to add the registered signed-overflow flag out_ovf.
module addn_seq #(
    parameter int LIMBS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    addn_seq_if.slave  bus
);
    localparam int W     = 16 * LIMBS;
    localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LIMBS - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic             carry_q, carry_d;
`ifdef ADDN_SEQ_OVF_EN
    // Operand sign bits are shifted out of a_q/b_q, so keep them aside.
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             ovf_q, ovf_d;
`endif

    logic run, done;
    assign run  = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
`ifdef ADDN_SEQ_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
`ifdef ADDN_SEQ_OVF_EN
                    sa_d    = bus.in_a[W-1];
                    sb_d    = bus.in_b[W-1];
`endif
                end
            end
            S_RUN: begin
                res_d[16*idx_q +: 16] = bus.add_sum;
                carry_d = bus.add_cout;
                a_d     = a_q >> 16;
                b_d     = b_q >> 16;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
`ifdef ADDN_SEQ_OVF_EN
                    // Bit 15 of the top limb's sum is sum[W-1].
                    ovf_d   = (sa_q == sb_q) && (bus.add_sum[15] != sa_q);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
`ifdef ADDN_SEQ_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
`ifdef ADDN_SEQ_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // add16 sees only register outputs, so its path starts right at the clock edge.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.add_a     = run ? a_q[15:0] : 16'h0;
    assign bus.add_b     = run ? b_q[15:0] : 16'h0;
    assign bus.add_cin   = run & carry_q;
    assign bus.out_valid = done;
    assign bus.out_sum   = done ? res_q : '0;
    assign bus.out_cout  = done & carry_q;
`ifdef ADDN_SEQ_OVF_EN
    assign bus.out_ovf   = done & ovf_q;
`endif
endmodule

// File: tb/tb_addn_seq.sv
// Scoreboard bench for addn_seq (LIMBS=4) with a combinational add16 model on the limb bus.
// Checks out_ovf too when ADDN_SEQ_OVF_EN is defined.
module tb_addn_seq;
    localparam int LIMBS = 4;
    localparam int W     = 16 * LIMBS;

    typedef struct {
        logic [W:0] val;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    addn_seq_if #(.LIMBS(LIMBS)) bus ();

    addn_seq #(.LIMBS(LIMBS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External add16: purely combinational.
    assign {bus.add_cout, bus.add_sum} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic and the signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        logic [W-1:0] s;
        e.val = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        s     = e.val[W-1:0];
        e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: pops and compares on every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 128'({bus.out_cout, bus.out_sum}), 128'(e.val));
`ifdef ADDN_SEQ_OVF_EN
                check("ovf", 128'(bus.out_ovf), 128'(e.ovf));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 128'(0), 128'(1));
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc      = cyc;
            bus.in_valid = 1'b0;
            exp_q.push_back(model(a, b, cin));
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 128'(0), 128'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_left", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stim_done;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values, observed while rst_n is low.
        #12;
        check("rst_in_ready",  128'(bus.in_ready),  128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_sum",   128'(bus.out_sum),   128'(0));
        check("rst_out_cout",  128'(bus.out_cout),  128'(0));
        check("rst_add_bus",   128'({bus.add_a, bus.add_b, bus.add_cin}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple and latency.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_valid();
        check("latency", 128'(cyc - acc_cyc), 128'(LIMBS));
        check("ripple_sum",  128'(bus.out_sum),  128'(0));
        check("ripple_cout", 128'(bus.out_cout), 128'(1));
        drain();

        // Carry-in only: add_cin high only in the first RUN cycle.
        issue(64'h0, 64'h0, 1'b1);
        for (int k = 0; k < LIMBS; k++) begin
            @(negedge clk);
            check($sformatf("cin_limb%0d", k), 128'(bus.add_cin), 128'(k == 0));
        end
        drain();

        // Backpressure with a pending request.
        bus.out_ready = 1'b0;
        issue(64'h0001_0000_0000_FFFF, 64'h1, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_a     = 64'd5;
        bus.in_b     = 64'd7;
        bus.in_cin   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid",    128'(bus.out_valid), 128'(1));
            check("bp_in_ready", 128'(bus.in_ready),  128'(0));
            check("bp_sum",      128'(bus.out_sum),   128'(64'h0001_0000_0001_0000));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", 128'(bus.in_ready),  128'(1));
        check("bp_idle_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(64'd5, 64'd7, 1'b0));
        @(negedge clk);
        check("bp_second_accepted", 128'(bus.in_ready), 128'(0));
        drain();

        // Reset after two limbs captured.
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid",    128'(bus.out_valid), 128'(0));
        check("midrst_sum",      128'(bus.out_sum),   128'(0));
        check("midrst_in_ready", 128'(bus.in_ready),  128'(1));
        check("midrst_add_bus",  128'({bus.add_a, bus.add_b, bus.add_cin}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(64'd5, 64'd7, 1'b0);
        drain();

        // Random operations with random output stalls.
        stim_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    logic [W-1:0] a, b;
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) a = '1;
                    if ($urandom_range(0, 7) == 0) b = ~a;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    issue(a, b, 1'($urandom_range(0, 1)));
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Signed-overflow patterns (sum and carry are checked in every build).
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        issue(64'h1, 64'h1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
